// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer: 8-bit LSB-first frame, optional parity, 1 or 2 stop bits
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rst        synchronous active-high reset; aborts any frame in progress
//   TxD_start  transmit request level; a frame starts on its rising edge while idle
//   TxD_data   byte to send; sampled only on the accepting edge
//   TxD        serial line, idle high, registered
//   busy       high for the whole frame, registered
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD,
    output logic       busy
);

    localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam bit                HAS_PARITY = (PARITY != 0);
    localparam logic              STOP_LAST  = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             start_q;

    logic             accept;
    logic             tick;

    // Only a rising edge of the request starts a frame; start_q resets high so
    // a request held through reset is not mistaken for a new one.
    assign accept = (state_q == S_IDLE) && TxD_start && !start_q;
    assign tick   = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        txd_d    = txd_q;
        busy_d   = busy_q;

        if (state_q != S_IDLE) begin
            baud_d = tick ? '0 : baud_q + 1'b1;
        end

        // TxD_d only changes on a tick or on accept, so the line never glitches
        // between bit boundaries.
        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (accept) begin
                    shift_d  = TxD_data;
                    parity_d = (PARITY == 2) ? ~(^TxD_data) : (^TxD_data);
                    state_d  = S_START;
                    txd_d    = 1'b0;
                    busy_d   = 1'b1;
                    bit_d    = '0;
                    stop_d   = 1'b0;
                end
            end

            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                    bit_d   = '0;
                end
            end

            S_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        if (HAS_PARITY) begin
                            state_d = S_PARITY;
                            txd_d   = parity_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        // shift_q[1] is the bit that becomes shift_q[0] after this shift
                        txd_d = shift_q[1];
                    end
                end
            end

            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                    stop_d  = 1'b0;
                end
            end

            S_STOP: begin
                if (tick) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        txd_d   = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                baud_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            start_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            start_q  <= TxD_start;
        end
    end

    assign TxD  = txd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

    localparam int CLKS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start;
    logic [7:0] data [3];
    wire  [2:0] txd;
    wire  [2:0] busy;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(CLKS), .PARITY(0), .STOP_BITS(1)) dut_none (
        .clk(clk), .rst(rst), .TxD_start(start[0]), .TxD_data(data[0]), .TxD(txd[0]), .busy(busy[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(CLKS), .PARITY(1), .STOP_BITS(2)) dut_even (
        .clk(clk), .rst(rst), .TxD_start(start[1]), .TxD_data(data[1]), .TxD(txd[1]), .busy(busy[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(CLKS), .PARITY(2), .STOP_BITS(2)) dut_odd (
        .clk(clk), .rst(rst), .TxD_start(start[2]), .TxD_data(data[2]), .TxD(txd[2]), .busy(busy[2]));

    function automatic int par_of(input int k);
        return k;
    endfunction

    function automatic int sb_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    // Reference line waveform: index i is TxD in the i-th cycle after the accepting edge.
    function automatic void build(input int par, input int sb, input logic [7:0] d,
                                  output logic [127:0] w, output int f);
        logic bits [$];
        bits.push_back(1'b0);
        for (int j = 0; j < 8; j++) bits.push_back(d[j]);
        if (par == 1) bits.push_back(^d);
        if (par == 2) bits.push_back(~(^d));
        for (int j = 0; j < sb; j++) bits.push_back(1'b1);
        f = bits.size() * CLKS;
        w = '1;
        for (int i = 0; i < f; i++) w[i] = bits[i / CLKS];
    endfunction

    // Receiver-style decode: sample the middle of each data bit after a start at index s.
    function automatic logic [7:0] decode(input logic [127:0] w, input int s);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = w[s + (1 + j) * CLKS + CLKS / 2];
        return r;
    endfunction

    function automatic logic [9:0] mid_bits(input logic [127:0] w);
        logic [9:0] r;
        for (int j = 0; j < 10; j++) r[j] = w[j * CLKS + CLKS / 2];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_check(input int k, input logic [7:0] d, input int hold_to,
                                  input int toggle_at, input string name,
                                  output logic [127:0] w, output int nbusy);
        logic [127:0] ew, eb, b;
        int f;
        build(par_of(k), sb_of(k), d, ew, f);
        eb = '0;
        for (int i = 0; i < f; i++) eb[i] = 1'b1;
        w = '1;
        b = '0;
        nbusy = 0;
        start[k] = 1'b0;
        step();
        step();
        data[k] = d;
        start[k] = 1'b1;
        @(posedge clk);
        for (int i = 0; i < f + 4; i++) begin
            @(negedge clk);
            w[i] = txd[k];
            b[i] = busy[k];
            if (busy[k]) nbusy++;
            if (i == 2) data[k] = ~d;
            if (toggle_at >= 0 && i == toggle_at) start[k] = 1'b0;
            if (toggle_at >= 0 && i == toggle_at + 2) start[k] = 1'b1;
            if (i == hold_to) start[k] = 1'b0;
        end
        start[k] = 1'b0;
        total++;
        if (w !== ew) begin
            bad++;
            $display("FAIL %s txd got=%h want=%h", name, w, ew);
        end
        total++;
        if (b !== eb) begin
            bad++;
            $display("FAIL %s busy got=%h want=%h", name, b, eb);
        end
    endtask

    task automatic test_reset();
        int bad_cycles [3];
        rst = 1'b1;
        start = 3'b111;
        step();
        step();
        total++;
        if (txd !== 3'b111 || busy !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs txd=%b busy=%b want txd=111 busy=000", txd, busy);
        end
        rst = 1'b0;
        bad_cycles = '{0, 0, 0};
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                if (txd[k] !== 1'b1 || busy[k] !== 1'b0) bad_cycles[k]++;
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bad_cycles[k] !== 0) begin
                bad++;
                $display("FAIL reset_held_start dut%0d active cycles got=%0d want=0", k, bad_cycles[k]);
            end
        end
        start = 3'b000;
    endtask

    task automatic test_basic();
        logic [127:0] w;
        int nb;
        send_and_check(0, 8'hA5, 0, -1, "basic_a5", w, nb);
        total++;
        if (nb !== 40) begin
            bad++;
            $display("FAIL basic_busy_len got=%0d want=40", nb);
        end
        total++;
        if (mid_bits(w) !== 10'b1101001010) begin
            bad++;
            $display("FAIL basic_bits got=%b want=%b", mid_bits(w), 10'b1101001010);
        end
    endtask

    task automatic test_handshake();
        logic [127:0] w;
        int nb;
        logic [7:0] d;
        d = 8'($urandom);
        send_and_check(0, d, 41, -1, "handshake", w, nb);
        total++;
        if (nb !== 40 || decode(w, 0) !== d) begin
            bad++;
            $display("FAIL handshake_frame busy=%0d byte=%h want busy=40 byte=%h", nb, decode(w, 0), d);
        end
    endtask

    task automatic test_parity();
        logic [127:0] w;
        int nb;
        send_and_check(1, 8'h07, 0, -1, "even_07", w, nb);
        total++;
        if (w[9 * CLKS + 2] !== 1'b1 || nb !== 48) begin
            bad++;
            $display("FAIL even_parity bit=%b busy=%0d want bit=1 busy=48", w[9 * CLKS + 2], nb);
        end
        send_and_check(2, 8'h07, 0, -1, "odd_07", w, nb);
        total++;
        if (w[9 * CLKS + 2] !== 1'b0 || nb !== 48) begin
            bad++;
            $display("FAIL odd_parity bit=%b busy=%0d want bit=0 busy=48", w[9 * CLKS + 2], nb);
        end
    endtask

    task automatic test_busy_ignore();
        logic [127:0] w;
        int nb;
        logic [7:0] d;
        d = 8'($urandom);
        send_and_check(1, d, 999, 8, "busy_ignore", w, nb);
        total++;
        if (nb !== 48 || decode(w, 0) !== d) begin
            bad++;
            $display("FAIL busy_ignore_frame busy=%0d byte=%h want busy=48 byte=%h", nb, decode(w, 0), d);
        end
    endtask

    task automatic test_mid_reset();
        logic [127:0] w;
        int nb;
        start[0] = 1'b0;
        step();
        step();
        data[0] = 8'h00;
        start[0] = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 0) start[0] = 1'b0;
        end
        total++;
        if (txd[0] !== 1'b0 || busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_pre txd=%b busy=%b want txd=0 busy=1", txd[0], busy[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (txd !== 3'b111 || busy !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset_edge txd=%b busy=%b want txd=111 busy=000", txd, busy);
        end
        rst = 1'b0;
        send_and_check(0, 8'hFF, 0, -1, "post_reset_ff", w, nb);
        total++;
        if (mid_bits(w) !== 10'b1111111110) begin
            bad++;
            $display("FAIL post_reset_bits got=%b want=%b", mid_bits(w), 10'b1111111110);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] w, e1, e2, ew;
        int f1, f2, fall;
        logic [7:0] d1;
        d1 = 8'($urandom);
        build(0, 1, d1, e1, f1);
        build(0, 1, 8'h3C, e2, f2);
        w = '1;
        fall = -1;
        start[0] = 1'b0;
        step();
        step();
        data[0] = d1;
        start[0] = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            w[i] = txd[0];
            if (fall < 0 && busy[0] == 1'b0) begin
                fall = i;
                start[0] = 1'b0;
            end else if (fall >= 0 && i == fall + 1) begin
                start[0] = 1'b1;
                data[0] = 8'h3C;
            end
            if (fall >= 0 && i == fall + 2 + f2 + 3) break;
        end
        start[0] = 1'b0;
        total++;
        if (fall !== f1) begin
            bad++;
            $display("FAIL b2b_busy_fall got=%0d want=%0d", fall, f1);
        end
        ew = '1;
        for (int i = 0; i < f1; i++) ew[i] = e1[i];
        for (int i = 0; i < f2; i++) ew[f1 + 2 + i] = e2[i];
        total++;
        if (w !== ew) begin
            bad++;
            $display("FAIL b2b_txd got=%h want=%h", w, ew);
        end
        total++;
        if (decode(w, 0) !== d1) begin
            bad++;
            $display("FAIL b2b_first_byte got=%h want=%h", decode(w, 0), d1);
        end
        total++;
        if (decode(w, f1 + 2) !== 8'h3C) begin
            bad++;
            $display("FAIL b2b_second_byte got=%h want=3c", decode(w, f1 + 2));
        end
    endtask

    task automatic test_random();
        logic [127:0] w;
        int nb, k;
        logic [7:0] d;
        for (int r = 0; r < 9; r++) begin
            k = $urandom_range(0, 2);
            d = 8'($urandom);
            send_and_check(k, d, $urandom_range(0, 30), -1, "random", w, nb);
            total++;
            if (decode(w, 0) !== d) begin
                bad++;
                $display("FAIL random_decode dut%0d got=%h want=%h", k, decode(w, 0), d);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 3'b111;
        for (int k = 0; k < 3; k++) data[k] = 8'h00;
        test_reset();
        test_basic();
        test_handshake();
        test_parity();
        test_busy_ignore();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
